// File: rtl/fan_tach_emulator.sv
// Fan tachometer emulator: turns a commanded RPM into a tach pulse train.
// An iterative restoring divider turns the command into a half-period. The
// result is held as a pending value and is only taken up at a tach edge, so
// that a half-period in progress is never cut short or stretched.
module fan_tach_emulator #(
    parameter int unsigned PULSES_PER_REVOLUTION = 2,
    parameter int unsigned CLOCK_RATE            = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rpmValid,
    input  logic [15:0] rpm,
    output logic        rpmReady,
    output logic        fanTach,
    output logic [15:0] currentRPM
);

    // Half-period = (CLOCK_RATE*60/2) / (rpm*PPR) clocks.
    localparam logic [31:0] DIVIDEND = 32'(64'(CLOCK_RATE) * 64'd30);
    localparam logic [18:0] PPR      = 19'(PULSES_PER_REVOLUTION);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_LOAD
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  iter_q, iter_d;
    logic [18:0] div_q, div_d;      // divisor rpm*PPR
    logic [18:0] rem_q, rem_d;      // partial remainder, always < divisor
    logic [31:0] quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
    logic [15:0] cmd_rpm_q, cmd_rpm_d;
    logic        cmd_stop_q, cmd_stop_d;
    logic        load_pend;

    // Pending value waiting for the next tach edge
    logic        pv_q, pv_d;
    logic        pstop_q, pstop_d;
    logic [15:0] prpm_q, prpm_d;
    logic [31:0] ph_q, ph_d;

    // Generator
    logic        run_q, run_d;
    logic        tach_q, tach_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] act_q, act_d;
    logic [15:0] cur_q, cur_d;

    logic [19:0] trial;
    logic        ge;
    logic [18:0] diff;
    logic [31:0] h_res;
    logic        toggle;

    assign rpmReady   = (state_q == S_IDLE);
    assign fanTach    = tach_q;
    assign currentRPM = cur_q;

    assign trial  = {rem_q, quo_q[31]};
    assign ge     = (trial >= {1'b0, div_q});
    assign diff   = trial[18:0] - div_q;
    assign h_res  = (quo_q == 32'd0) ? 32'd1 : quo_q;
    assign toggle = run_q && (cnt_q == 32'd0);

    // Command FSM: accept in IDLE, 32 divide iterations, one LOAD cycle
    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        load_pend = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rpmValid) begin
                    state_d = (rpm == 16'd0) ? S_LOAD : S_DIVIDE;
                    iter_d  = 5'd0;
                end
            end
            S_DIVIDE: begin
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'd31) state_d = S_LOAD;
            end
            S_LOAD: begin
                load_pend = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Divider datapath: capture command on accept, one quotient bit per DIVIDE cycle
    always_comb begin
        div_d      = div_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cmd_rpm_d  = cmd_rpm_q;
        cmd_stop_d = cmd_stop_q;
        if (state_q == S_IDLE && rpmValid) begin
            div_d      = 19'(rpm) * PPR;
            rem_d      = '0;
            quo_d      = DIVIDEND;
            cmd_rpm_d  = rpm;
            cmd_stop_d = (rpm == 16'd0);
        end else if (state_q == S_DIVIDE) begin
            rem_d = ge ? diff : trial[18:0];
            quo_d = {quo_q[30:0], ge};
        end
    end

    // Generator and pending slot: a toggle sees the pending value from before this edge
    always_comb begin
        run_d   = run_q;
        tach_d  = tach_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        cur_d   = cur_q;
        pv_d    = pv_q;
        pstop_d = pstop_q;
        prpm_d  = prpm_q;
        ph_d    = ph_q;

        if (toggle) begin
            if (pv_q && pstop_q) begin
                tach_d = 1'b1;
                run_d  = 1'b0;
                cur_d  = 16'd0;
            end else if (pv_q) begin
                tach_d = ~tach_q;
                cnt_d  = ph_q - 32'd1;
                act_d  = ph_q;
                cur_d  = prpm_q;
            end else begin
                tach_d = ~tach_q;
                cnt_d  = act_q - 32'd1;
            end
            pv_d = 1'b0;
        end else if (run_q) begin
            cnt_d = cnt_q - 32'd1;
        end else if (pv_q) begin
            // Stopped: start a new rate immediately from the high level
            if (!pstop_q) begin
                run_d  = 1'b1;
                tach_d = 1'b1;
                cnt_d  = ph_q - 32'd1;
                act_d  = ph_q;
                cur_d  = prpm_q;
            end
            pv_d = 1'b0;
        end

        // A fresh result overwrites whatever is (or was just) pending
        if (load_pend) begin
            pv_d    = 1'b1;
            pstop_d = cmd_stop_q;
            prpm_d  = cmd_rpm_q;
            ph_d    = h_res;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            iter_q     <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cmd_rpm_q  <= '0;
            cmd_stop_q <= 1'b0;
            pv_q       <= 1'b0;
            pstop_q    <= 1'b0;
            prpm_q     <= '0;
            ph_q       <= '0;
            run_q      <= 1'b0;
            tach_q     <= 1'b1;
            cnt_q      <= '0;
            act_q      <= '0;
            cur_q      <= '0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cmd_rpm_q  <= cmd_rpm_d;
            cmd_stop_q <= cmd_stop_d;
            pv_q       <= pv_d;
            pstop_q    <= pstop_d;
            prpm_q     <= prpm_d;
            ph_q       <= ph_d;
            run_q      <= run_d;
            tach_q     <= tach_d;
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            cur_q      <= cur_d;
        end
    end

endmodule

// File: tb/tb_fan_tach_emulator.sv
// Bench for fan_tach_emulator: two instances (PPR 2 and PPR 4, scaled-down
// clock rate) checked every cycle against a timestamp-based model, plus
// hand-computed phase lengths and reset values.
module tb_fan_tach_emulator;

    localparam int unsigned CR = 100000;       // N = 3,000,000

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld  [2];
    logic [15:0] rpmv [2];
    logic        rdy  [2];
    logic        tach [2];
    logic [15:0] cur  [2];

    int checks   = 0;
    int failures = 0;
    longint cyc  = 0;

    always #5 clk = ~clk;

    fan_tach_emulator #(.PULSES_PER_REVOLUTION(2), .CLOCK_RATE(CR)) u_a (
        .clk(clk), .rst_n(rst_n), .rpmValid(vld[0]), .rpm(rpmv[0]),
        .rpmReady(rdy[0]), .fanTach(tach[0]), .currentRPM(cur[0]));

    fan_tach_emulator #(.PULSES_PER_REVOLUTION(4), .CLOCK_RATE(CR)) u_b (
        .clk(clk), .rst_n(rst_n), .rpmValid(vld[1]), .rpm(rpmv[1]),
        .rpmReady(rdy[1]), .fanTach(tach[1]), .currentRPM(cur[1]));

    // ---------------- behavioural model ----------------
    // Tracks the time of the next tach edge instead of a counter.
    longint ppr [2] = '{2, 4};
    bit     m_rdy [2], m_busy [2], m_pv [2], m_pstop [2], m_sstop [2], m_run [2], m_tach [2];
    longint m_due [2], m_next [2], m_h [2], m_ph [2], m_sh [2];
    longint m_rpm [2], m_prpm [2], m_srpm [2];

    function automatic longint half_of(longint r, longint p);
        longint h;
        h = (longint'(CR) * 30) / (r * p);
        return (h == 0) ? 1 : h;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_rdy[k] = 1; m_busy[k] = 0; m_pv[k] = 0; m_run[k] = 0;
                m_tach[k] = 1; m_rpm[k] = 0; m_h[k] = 0;
            end
        end else if (clk) begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                bit o_rdy, o_pv, o_stop;
                longint o_h, o_rpm;
                o_rdy = m_rdy[k]; o_pv = m_pv[k]; o_stop = m_pstop[k];
                o_h = m_ph[k]; o_rpm = m_prpm[k];
                if (m_run[k]) begin
                    if (cyc == m_next[k]) begin
                        if (o_pv && o_stop) begin
                            m_tach[k] = 1; m_run[k] = 0; m_rpm[k] = 0;
                        end else begin
                            m_tach[k] = !m_tach[k];
                            if (o_pv) begin m_h[k] = o_h; m_rpm[k] = o_rpm; end
                            m_next[k] = cyc + m_h[k];
                        end
                        m_pv[k] = 0;
                    end
                end else if (o_pv) begin
                    if (!o_stop) begin
                        m_run[k] = 1; m_tach[k] = 1; m_h[k] = o_h; m_rpm[k] = o_rpm;
                        m_next[k] = cyc + o_h;
                    end
                    m_pv[k] = 0;
                end
                if (m_busy[k] && cyc == m_due[k]) begin
                    m_pv[k] = 1; m_pstop[k] = m_sstop[k]; m_ph[k] = m_sh[k]; m_prpm[k] = m_srpm[k];
                    m_busy[k] = 0; m_rdy[k] = 1;
                end
                if (o_rdy && vld[k]) begin
                    m_busy[k] = 1; m_rdy[k] = 0;
                    m_srpm[k]  = rpmv[k];
                    m_sstop[k] = (rpmv[k] == 0);
                    m_sh[k]    = (rpmv[k] == 0) ? 0 : half_of(rpmv[k], ppr[k]);
                    m_due[k]   = cyc + ((rpmv[k] == 0) ? 1 : 33);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rdy[k] !== m_rdy[k] || tach[k] !== m_tach[k] || longint'(cur[k]) != m_rpm[k]) begin
                    failures++;
                    $display("FAIL cmp[%0d] cyc=%0d got rdy=%b tach=%b rpm=%0d expected rdy=%b tach=%b rpm=%0d",
                             k, cyc, rdy[k], tach[k], cur[k], m_rdy[k], m_tach[k], m_rpm[k]);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input int k, input logic [15:0] r, input bit hold, output int lowcnt);
        int n;
        n = 0;
        while (!rdy[k] && n < 200) begin @(negedge clk); n++; end
        vld[k] = 1'b1; rpmv[k] = r;
        @(negedge clk);
        if (hold) rpmv[k] = 16'd1234;
        else      vld[k]  = 1'b0;
        lowcnt = 0;
        while (!rdy[k] && lowcnt < 200) begin lowcnt++; @(negedge clk); end
        vld[k] = 1'b0;
    endtask

    task automatic wait_edge(input int k, input logic lvl, output longint t);
        int n;
        n = 0;
        while (tach[k] == lvl && n < 5000) begin @(negedge clk); n++; end
        while (tach[k] != lvl && n < 5000) begin @(negedge clk); n++; end
        if (tach[k] != lvl) begin
            checks++; failures++;
            $display("FAIL wait_edge[%0d] timeout got level=%b required=%b", k, tach[k], lvl);
        end
        t = cyc;
    endtask

    task automatic count_edges(input int k, input int ncyc, output int e);
        logic prev;
        prev = tach[k];
        e = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (tach[k] != prev) e++;
            prev = tach[k];
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        longint t0, t1, t2, t3;
        int n, e;
        logic [15:0] btab [5];
        btab = '{16'd65535, 16'd40000, 16'd0, 16'd62000, 16'd50001};

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin vld[k] = 1'b0; rpmv[k] = 16'd0; end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_tach", tach[k], 1);
            chk("reset_rpm", cur[k], 0);
            chk("reset_ready", rdy[k], 1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Instance B: 60000 rpm, PPR 4 -> H = 3000000/240000 = 12
        send(1, 16'd60000, 0, n);
        @(negedge clk);
        t0 = cyc;
        chk("b_rpm_apply", cur[1], 60000);
        chk("b_model_h", m_h[1], 12);
        wait_edge(1, 1'b0, t1);
        chk("b_first_fall", t1 - t0, 12);
        wait_edge(1, 1'b1, t2);
        chk("b_low_phase", t2 - t1, 12);
        wait_edge(1, 1'b0, t3);
        chk("b_high_phase", t3 - t2, 12);
        // Back-to-back rate changes on B; the per-cycle compare covers them
        for (int i = 0; i < 5; i++) begin
            send(1, btab[i], 0, n);
            repeat (3 + 7 * i) @(negedge clk);
        end

        // A: 3000 rpm with junk held on rpmValid during the divide -> H = 500
        send(0, 16'd3000, 1, n);
        chk("a_ready_low", n, 33);
        chk("a_rpm_before_apply", cur[0], 0);
        @(negedge clk);
        t0 = cyc;
        chk("a_rpm_apply", cur[0], 3000);
        chk("a_model_h", m_h[0], 500);
        wait_edge(0, 1'b0, t1);
        chk("a_first_fall", t1 - t0, 500);
        wait_edge(0, 1'b1, t2);
        wait_edge(0, 1'b0, t3);
        chk("a_period", t3 - t1, 1000);
        chk("a_not_junk", cur[0], 3000);

        // Rate change 100 clks into a low half
        repeat (100) @(negedge clk);
        send(0, 16'd6000, 0, n);
        wait_edge(0, 1'b1, t1);
        chk("a_half_kept", t1 - t3, 500);
        chk("a_rpm_6000", cur[0], 6000);
        wait_edge(0, 1'b0, t2);
        chk("a_half_250a", t2 - t1, 250);
        wait_edge(0, 1'b1, t3);
        chk("a_half_250b", t3 - t2, 250);

        // Stop while low: rises at the next toggle, then holds
        wait_edge(0, 1'b0, t1);
        repeat (20) @(negedge clk);
        send(0, 16'd0, 0, n);
        chk("a_stop_busy", n, 1);
        wait_edge(0, 1'b1, t2);
        chk("a_stop_rise", t2 - t1, 250);
        chk("a_stop_rpm", cur[0], 0);
        count_edges(0, 2000, e);
        chk("a_stop_edges", e, 0);

        // Restart then stop while high: no extra edge
        send(0, 16'd3000, 0, n);
        repeat (50) @(negedge clk);
        chk("a_restart_rpm", cur[0], 3000);
        send(0, 16'd0, 0, n);
        count_edges(0, 2000, e);
        chk("a_stop_high_edges", e, 0);
        chk("a_stop_high_level", tach[0], 1);
        chk("a_stop_high_rpm", cur[0], 0);

        // Reset during a divide with tach low
        send(0, 16'd6000, 0, n);
        wait_edge(0, 1'b0, t1);
        vld[0] = 1'b1; rpmv[0] = 16'd3000;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_reset_tach", tach[0], 0);
        chk("pre_reset_busy", rdy[0], 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_tach", tach[0], 1);
        chk("async_rpm", cur[0], 0);
        chk("async_ready", rdy[0], 1);
        chk("async_b_rpm", cur[1], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_edges(0, 10000, e);
        chk("post_reset_edges_a", e, 0);
        chk("post_reset_ready", rdy[0], 1);
        chk("post_reset_rpm", cur[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
